// File: rtl/ex_mem_stage_pkg.sv
// Shared definitions for the execute stage: width constants, ALU op / funct encodings
// and the multiplier sequencing state type.
package ex_pkg;

  localparam int unsigned EX_DATA_W = 32;
  localparam int unsigned EX_REG_AW = 5;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;
  localparam logic [5:0] FUNCT_MULT = 6'b011000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } ex_state_t;

  // Branch target: next pc plus word-scaled immediate.
  function automatic logic [EX_DATA_W-1:0] calc_branch_target(
    input logic [EX_DATA_W-1:0] nextpc,
    input logic [EX_DATA_W-1:0] imm
  );
    return nextpc + {imm[EX_DATA_W-3:0], 2'b00};
  endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// ID/EX -> EX -> EX/MEM signal bundle.
//  slave  : execute stage view (ID/EX fields and stall/flush in, EX/MEM fields out)
//  master : surrounding pipeline view (drives ID/EX fields, observes EX/MEM fields)
interface ex_mem_stage_if
  import ex_pkg::*;
#(
  parameter int unsigned DATA_W = EX_DATA_W,
  parameter int unsigned REG_AW = EX_REG_AW
) ();

  // ID/EX side
  logic              valid_in;
  logic              reg_write_in;
  logic              mem_to_reg_in;
  logic              mem_write_in;
  logic              mem_read_in;
  logic              branch_in;
  logic              alu_src_in;
  logic [1:0]        alu_op_in;
  logic [REG_AW-1:0] rd_in;
  logic [DATA_W-1:0] nextpc_in;
  logic [DATA_W-1:0] rs_data_in;
  logic [DATA_W-1:0] rt_data_in;
  logic [DATA_W-1:0] sgn_ext_imm_in;
  logic              stall_in;
  logic              flush_in;
  logic              ex_busy;

  // EX/MEM side
  logic              reg_write_out;
  logic              mem_to_reg_out;
  logic              mem_write_out;
  logic              mem_read_out;
  logic [DATA_W-1:0] alu_result_out;
  logic [DATA_W-1:0] rt_data_out;
  logic [REG_AW-1:0] rd_out;
  logic              valid_out;
  logic              pc_src;
  logic              flush_out;
  logic [DATA_W-1:0] branch_target;

  modport slave (
    input  valid_in, reg_write_in, mem_to_reg_in, mem_write_in, mem_read_in, branch_in,
           alu_src_in, alu_op_in, rd_in, nextpc_in, rs_data_in, rt_data_in, sgn_ext_imm_in,
           stall_in, flush_in,
    output ex_busy, reg_write_out, mem_to_reg_out, mem_write_out, mem_read_out,
           alu_result_out, rt_data_out, rd_out, valid_out, pc_src, flush_out, branch_target
  );

  modport master (
    output valid_in, reg_write_in, mem_to_reg_in, mem_write_in, mem_read_in, branch_in,
           alu_src_in, alu_op_in, rd_in, nextpc_in, rs_data_in, rt_data_in, sgn_ext_imm_in,
           stall_in, flush_in,
    input  ex_busy, reg_write_out, mem_to_reg_out, mem_write_out, mem_read_out,
           alu_result_out, rt_data_out, rd_out, valid_out, pc_src, flush_out, branch_target
  );

endinterface

// File: rtl/ex_mem_stage_iter_mult.sv
// Iterative shift-add multiplier, one partial product per clock.
//  clk, reset : clock, asynchronous active-low reset
//  start      : load operands a/b and begin (ignored while clear is high)
//  clear      : abandon any operation in progress
//  a, b       : operands
//  done       : high during the final iteration cycle; product is valid the cycle after
//  product    : low DATA_W bits of a*b
module iter_mult #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MUL_CYCLES = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              clear,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int unsigned    CntW    = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MUL_CYCLES - 1);

  logic              busy_q, busy_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] acc_q, acc_d;

  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (clear) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      if (cnt_q == CntLast) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  assign done    = busy_q && (cnt_q == CntLast);
  assign product = acc_q;

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage plus EX/MEM pipeline register. Computes the ALU result and beq target from
// the ID/EX fields, resolves beq (pc_src/flush_out pulse, registered branch_target) and
// registers everything for MEM.
//  clk   : rising-edge clock
//  reset : asynchronous, active-low
//  bus   : ex_mem_stage_if.slave -- ID/EX inputs, stall_in/flush_in, ex_busy, EX/MEM outputs
// Build option: define EX_MUL_EN to add funct 011000 (mult), executed by an iterative
// multiplier over MUL_CYCLES clocks; otherwise mult decodes as an unknown funct.
module ex_mem_stage
  import ex_pkg::*;
#(
  parameter int unsigned DATA_W     = EX_DATA_W,
  parameter int unsigned REG_AW     = EX_REG_AW,
  parameter int unsigned MUL_CYCLES = 32
) (
  input logic           clk,
  input logic           reset,
  ex_mem_stage_if.slave bus
);

  // ---------------- ALU and branch resolution ----------------
  logic [DATA_W-1:0] op_a, op_b, sum, diff, alu_res, br_target;
  logic [5:0]        funct;
  logic              lt_signed, taken;

  assign op_a      = bus.rs_data_in;
  assign op_b      = bus.alu_src_in ? bus.sgn_ext_imm_in : bus.rt_data_in;
  assign sum       = op_a + op_b;
  assign diff      = op_a - op_b;
  assign funct     = bus.sgn_ext_imm_in[5:0];
  assign lt_signed = $signed(op_a) < $signed(op_b);
  assign taken     = bus.valid_in & bus.branch_in & (diff == '0);
  assign br_target = calc_branch_target(bus.nextpc_in, bus.sgn_ext_imm_in);

  always_comb begin
    alu_res = '0;
    case (bus.alu_op_in)
      ALUOP_SUB: alu_res = diff;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: alu_res = sum;
          FUNCT_SUB: alu_res = diff;
          FUNCT_AND: alu_res = op_a & op_b;
          FUNCT_OR:  alu_res = op_a | op_b;
          FUNCT_SLT: alu_res = {{(DATA_W-1){1'b0}}, lt_signed};
          default:   alu_res = '0;
        endcase
      end
      default: alu_res = sum;
    endcase
  end

  // ---------------- Optional multiplier sequencing ----------------
  logic              mul_bubble;  // register a bubble this edge (mult accepted or running)
  logic              mul_load;    // register the finished product this edge
  logic [DATA_W-1:0] mul_product;

`ifdef EX_MUL_EN
  ex_state_t state_q, state_d;
  logic      is_mult, mul_start, mul_done;

  assign is_mult   = bus.valid_in && (bus.alu_op_in == ALUOP_RTYPE) && (funct == FUNCT_MULT);
  assign mul_start = (state_q == IDLE) && is_mult && !bus.flush_in && !bus.stall_in;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mul_start) state_d = MUL;
      MUL:     if (mul_done) state_d = DONE;
      DONE:    if (!bus.stall_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.flush_in) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  iter_mult #(
    .DATA_W     (DATA_W),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_iter_mult (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .clear   (bus.flush_in),
    .a       (op_a),
    .b       (op_b),
    .done    (mul_done),
    .product (mul_product)
  );

  assign mul_bubble  = mul_start || (state_q == MUL);
  assign mul_load    = (state_q == DONE);
  // ID/EX keeps the mult in place until DONE, so its control bits are still valid then.
  assign bus.ex_busy = bus.stall_in || mul_start || (state_q == MUL);
`else
  assign mul_bubble  = 1'b0;
  assign mul_load    = 1'b0;
  assign mul_product = '0;
  assign bus.ex_busy = bus.stall_in;
`endif

  // ---------------- EX/MEM register ----------------
  logic              valid_q, valid_d;
  logic              reg_write_q, reg_write_d;
  logic              mem_to_reg_q, mem_to_reg_d;
  logic              mem_write_q, mem_write_d;
  logic              mem_read_q, mem_read_d;
  logic              pc_src_q, pc_src_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] target_q, target_d;
  logic              kill, load;

  // flush beats stall; a stalled edge holds every register, pc_src included.
  assign kill = bus.flush_in || (!bus.stall_in && mul_bubble);
  assign load = !bus.flush_in && !bus.stall_in && !mul_bubble;

  always_comb begin
    valid_d      = valid_q;
    reg_write_d  = reg_write_q;
    mem_to_reg_d = mem_to_reg_q;
    mem_write_d  = mem_write_q;
    mem_read_d   = mem_read_q;
    pc_src_d     = pc_src_q;
    result_d     = result_q;
    rt_data_d    = rt_data_q;
    rd_d         = rd_q;
    target_d     = target_q;
    if (kill) begin
      valid_d      = 1'b0;
      reg_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      mem_write_d  = 1'b0;
      mem_read_d   = 1'b0;
      pc_src_d     = 1'b0;
    end else if (load) begin
      valid_d      = bus.valid_in;
      // A taken beq travels on but must not write anything.
      reg_write_d  = bus.valid_in & bus.reg_write_in & ~taken;
      mem_write_d  = bus.valid_in & bus.mem_write_in & ~taken;
      mem_to_reg_d = bus.valid_in & bus.mem_to_reg_in;
      mem_read_d   = bus.valid_in & bus.mem_read_in;
      pc_src_d     = taken;
      result_d     = mul_load ? mul_product : alu_res;
      rt_data_d    = bus.rt_data_in;
      rd_d         = bus.rd_in;
      target_d     = br_target;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      pc_src_q     <= 1'b0;
      result_q     <= '0;
      rt_data_q    <= '0;
      rd_q         <= '0;
      target_q     <= '0;
    end else begin
      valid_q      <= valid_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      mem_write_q  <= mem_write_d;
      mem_read_q   <= mem_read_d;
      pc_src_q     <= pc_src_d;
      result_q     <= result_d;
      rt_data_q    <= rt_data_d;
      rd_q         <= rd_d;
      target_q     <= target_d;
    end
  end

  assign bus.valid_out      = valid_q;
  assign bus.reg_write_out  = reg_write_q;
  assign bus.mem_to_reg_out = mem_to_reg_q;
  assign bus.mem_write_out  = mem_write_q;
  assign bus.mem_read_out   = mem_read_q;
  assign bus.pc_src         = pc_src_q;
  assign bus.flush_out      = pc_src_q;
  assign bus.alu_result_out = result_q;
  assign bus.rt_data_out    = rt_data_q;
  assign bus.rd_out         = rd_q;
  assign bus.branch_target  = target_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: expected EX/MEM contents are pushed to a queue
// when an instruction is driven and popped/compared after the clock edge.
module tb_ex_mem_stage;
  import ex_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ex_mem_stage_if bus ();

  ex_mem_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        v, rw, mtr, mw, mr, ps;
    logic [31:0] res, rt, tgt;
    logic [4:0]  rd;
  } exp_t;

  typedef struct {
    logic        v, rw, mtr, mw, mr, br, asrc, stall, flush;
    logic [1:0]  op;
    logic [4:0]  rd;
    logic [31:0] npc, a, rt, imm;
  } stim_t;

  exp_t  sb[$];
  exp_t  last_exp;
  stim_t s;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_alu(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] imm);
    logic [31:0] r;
    if (op == 2'b01) r = a - b;
    else if (op == 2'b10) begin
      if (imm[5:0] == 6'h20) r = a + b;
      else if (imm[5:0] == 6'h22) r = a - b;
      else if (imm[5:0] == 6'h24) r = a & b;
      else if (imm[5:0] == 6'h25) r = a | b;
      else if (imm[5:0] == 6'h2a) r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      else r = 32'd0;
    end else r = a + b;
    return r;
  endfunction

  task automatic drive(input stim_t t);
    bus.valid_in       = t.v;
    bus.reg_write_in   = t.rw;
    bus.mem_to_reg_in  = t.mtr;
    bus.mem_write_in   = t.mw;
    bus.mem_read_in    = t.mr;
    bus.branch_in      = t.br;
    bus.alu_src_in     = t.asrc;
    bus.alu_op_in      = t.op;
    bus.rd_in          = t.rd;
    bus.nextpc_in      = t.npc;
    bus.rs_data_in     = t.a;
    bus.rt_data_in     = t.rt;
    bus.sgn_ext_imm_in = t.imm;
    bus.stall_in       = t.stall;
    bus.flush_in       = t.flush;
  endtask

  // Called just after a rising edge: drive, predict, clock, compare.
  task automatic apply(input string tag, input stim_t t);
    exp_t        e;
    logic [31:0] b;
    logic        tk;
    drive(t);
    e = last_exp;
    if (t.flush) begin
      e.v = 0; e.rw = 0; e.mtr = 0; e.mw = 0; e.mr = 0; e.ps = 0;
    end else if (!t.stall) begin
      b     = t.asrc ? t.imm : t.rt;
      tk    = t.v && t.br && (t.a == b);
      e.v   = t.v;
      e.rw  = t.v && t.rw && !tk;
      e.mw  = t.v && t.mw && !tk;
      e.mtr = t.v && t.mtr;
      e.mr  = t.v && t.mr;
      e.ps  = tk;
      e.res = model_alu(t.op, t.a, b, t.imm);
      e.rt  = t.rt;
      e.rd  = t.rd;
      e.tgt = t.npc + t.imm * 4;
    end
    sb.push_back(e);
    last_exp = e;
    #1;
    check_eq({tag, ".ex_busy"}, {31'd0, bus.ex_busy}, {31'd0, t.stall});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_eq({tag, ".valid_out"}, {31'd0, bus.valid_out}, {31'd0, e.v});
    check_eq({tag, ".reg_write_out"}, {31'd0, bus.reg_write_out}, {31'd0, e.rw});
    check_eq({tag, ".mem_to_reg_out"}, {31'd0, bus.mem_to_reg_out}, {31'd0, e.mtr});
    check_eq({tag, ".mem_write_out"}, {31'd0, bus.mem_write_out}, {31'd0, e.mw});
    check_eq({tag, ".mem_read_out"}, {31'd0, bus.mem_read_out}, {31'd0, e.mr});
    check_eq({tag, ".pc_src"}, {31'd0, bus.pc_src}, {31'd0, e.ps});
    check_eq({tag, ".flush_out"}, {31'd0, bus.flush_out}, {31'd0, e.ps});
    if (e.v) begin
      check_eq({tag, ".alu_result_out"}, bus.alu_result_out, e.res);
      check_eq({tag, ".rt_data_out"}, bus.rt_data_out, e.rt);
      check_eq({tag, ".rd_out"}, {27'd0, bus.rd_out}, {27'd0, e.rd});
    end
    if (e.ps) check_eq({tag, ".branch_target"}, bus.branch_target, e.tgt);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".valid_out"}, {31'd0, bus.valid_out}, 32'd0);
    check_eq({tag, ".ctrl"}, {28'd0, bus.reg_write_out, bus.mem_to_reg_out,
                              bus.mem_write_out, bus.mem_read_out}, 32'd0);
    check_eq({tag, ".pc_src"}, {30'd0, bus.pc_src, bus.flush_out}, 32'd0);
    check_eq({tag, ".alu_result_out"}, bus.alu_result_out, 32'd0);
    check_eq({tag, ".rt_data_out"}, bus.rt_data_out, 32'd0);
    check_eq({tag, ".rd_out"}, {27'd0, bus.rd_out}, 32'd0);
    check_eq({tag, ".branch_target"}, bus.branch_target, 32'd0);
  endtask

  function automatic stim_t r_type(input logic [5:0] fn, input logic [31:0] a,
                                   input logic [31:0] rt, input logic [4:0] rd);
    stim_t t = '{default: 0};
    t.v = 1; t.rw = 1; t.op = 2'b10; t.imm = {26'd0, fn}; t.a = a; t.rt = rt; t.rd = rd;
    return t;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    s = '{default: 0};
    drive(s);
    last_exp = '{default: 0};
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // R-type ALU functions
    apply("r_add", r_type(6'h20, 32'd5, 32'd7, 5'd3));
    apply("r_sub", r_type(6'h22, 32'd5, 32'd7, 5'd4));
    apply("r_and", r_type(6'h24, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd5));
    apply("r_or", r_type(6'h25, 32'hF000_0001, 32'h0000_0F10, 5'd6));
    apply("slt_neg", r_type(6'h2a, 32'hFFFF_FFFF, 32'd1, 5'd7));
    apply("slt_pos", r_type(6'h2a, 32'd1, 32'hFFFF_FFFF, 5'd7));
    apply("r_unknown", r_type(6'h3f, 32'd9, 32'd9, 5'd8));
    apply("r_mult_code", r_type(6'h18, 32'd6, 32'd7, 5'd9));

    // beq taken then not taken
    s = '{default: 0};
    s.v = 1; s.br = 1; s.rw = 1; s.op = 2'b01; s.a = 9; s.rt = 9; s.npc = 32'h100; s.imm = 3;
    apply("beq_taken", s);
    s.rt = 8; s.rw = 0;
    apply("beq_not_taken", s);

    // bubble: controls forced low
    s = '{default: 0};
    s.rw = 1; s.mw = 1; s.mr = 1; s.mtr = 1; s.a = 3; s.rt = 4;
    apply("bubble", s);

    // lw then a 3-cycle stall with different inputs presented
    s = '{default: 0};
    s.v = 1; s.rw = 1; s.mtr = 1; s.mr = 1; s.asrc = 1; s.op = 2'b00; s.a = 32'h40; s.imm = 4;
    s.rd = 5'd10;
    apply("lw", s);
    s = r_type(6'h20, 32'd1, 32'd1, 5'd11);
    s.stall = 1;
    for (int i = 0; i < 3; i++) apply("stall", s);
    s.stall = 0;
    apply("after_stall", s);

    // taken branch, then stall holds pc_src as registered
    s = '{default: 0};
    s.v = 1; s.br = 1; s.op = 2'b01; s.a = 32'h55; s.rt = 32'h55; s.npc = 32'h200;
    s.imm = 32'hFFFF_FFFE;
    apply("beq_back", s);
    s.stall = 1;
    apply("beq_stall", s);

    // sw, then flush+stall on one edge
    s = '{default: 0};
    s.v = 1; s.mw = 1; s.asrc = 1; s.a = 32'h80; s.imm = 8; s.rt = 32'hDEAD;
    apply("sw", s);
    s.stall = 1; s.flush = 1;
    apply("flush_stall", s);
    s = r_type(6'h20, 32'd2, 32'd3, 5'd12);
    apply("pre_flush", s);
    s.flush = 1;
    apply("flush", s);

    // reset mid-stream: outputs clear before the next edge
    apply("pre_reset", r_type(6'h20, 32'd100, 32'd23, 5'd13));
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    s = '{default: 0};
    drive(s);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    last_exp = '{default: 0};
    apply("recover", r_type(6'h22, 32'd50, 32'd8, 5'd14));

`ifdef EX_MUL_EN
    begin
      int n;
      s = r_type(6'h18, 32'hFFFF_FFFF, 32'd3, 5'd15);
      drive(s);
      #1;
      n = 0;
      while (bus.ex_busy && n < 100) begin
        n++;
        @(posedge clk);
        #1;
        check_eq("mul_bubble", {31'd0, bus.valid_out}, 32'd0);
      end
      check_eq("mul_busy_len", n, 32'd33);
      @(posedge clk);
      #1;
      check_eq("mul_result", bus.alu_result_out, 32'hFFFF_FFFD);
      check_eq("mul_valid", {31'd0, bus.valid_out}, 32'd1);
      check_eq("mul_reg_write", {31'd0, bus.reg_write_out}, 32'd1);
      last_exp = '{default: 0};
      last_exp.v = 1; last_exp.rw = 1; last_exp.res = 32'hFFFF_FFFD; last_exp.rt = 3;
      last_exp.rd = 5'd15;

      // flush mid-multiply: nothing emerges
      s = r_type(6'h18, 32'd7, 32'd9, 5'd16);
      drive(s);
      repeat (5) @(posedge clk);
      #1;
      s.flush = 1;
      drive(s);
      @(posedge clk);
      #1;
      s = '{default: 0};
      drive(s);
      for (int i = 0; i < 40; i++) begin
        @(posedge clk);
        #1;
        check_eq("mul_flushed_valid", {31'd0, bus.valid_out}, 32'd0);
        check_eq("mul_flushed_busy", {31'd0, bus.ex_busy}, 32'd0);
      end
      check_eq("mul_flushed_result", {31'd0, bus.alu_result_out == 32'd63}, 32'd0);
      last_exp = '{default: 0};
      apply("after_mul", r_type(6'h20, 32'd1, 32'd2, 5'd17));
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
